// File: rtl/clk_gate_pkg.sv
// Shared types and reset values for the multi-channel clock-gating controller.
package clk_gate_pkg;

    // Per-channel gating state: running, counting idle cycles, or clock gated
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        GATED = 2'd2
    } ch_state_e;

    localparam ch_state_e RST_STATE = RUN;
    localparam logic      RST_GATED = 1'b0;
    localparam logic      RST_WIRE  = 1'b0;

endpackage

// File: rtl/clk_gate_ch.sv
// One clock-gating channel: idle-hysteresis FSM, combinational ICG enable,
// saturating gated-cycle counter and the clock gate cell itself.
module clk_gate_ch
    import clk_gate_pkg::*;
#(
    parameter int HOLD_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              cptra_rst,
    input  logic              clk_gate_en,
    input  logic              rdc_clk_dis,
    input  logic              cpu_halt_status,
    input  logic              wire_chg,
    input  logic              ch_busy,
    input  logic              ch_gate_mask,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic              cnt_clr,
    output logic              ch_en,
    output logic              clk_cg,
    output logic              ch_gated,
    output logic [CNT_W-1:0]  gated_cycles
);

    ch_state_e          r_state;
    logic [HOLD_W-1:0]  r_hcnt;
    logic               r_ch_gated;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_wake;
    logic               w_hold_done;
    logic               w_ch_en;

    // Any of these keeps the channel clock alive this cycle
    assign w_wake = wire_chg | ~cpu_halt_status | ch_busy | ~clk_gate_en | ~ch_gate_mask;

    // hcnt+1 >= hold_cycles, computed one bit wider so a hold value lowered
    // below the running count (or set to zero) still gates instead of wrapping
    assign w_hold_done = ({1'b0, r_hcnt} + {{HOLD_W{1'b0}}, 1'b1}) >= {1'b0, hold_cycles};

    // Wake re-enables the clock with no register in the path; reset keeps it running
    assign w_ch_en = ~rdc_clk_dis & (cptra_rst | (r_state != GATED) | w_wake);

    // Hysteresis FSM with the registered gated flag tracking the next state
    always_ff @(posedge clk) begin
        if (cptra_rst) begin
            r_state    <= RST_STATE;
            r_hcnt     <= '0;
            r_ch_gated <= RST_GATED;
        end else if (rdc_clk_dis) begin
            r_state    <= RUN;
            r_hcnt     <= '0;
            r_ch_gated <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (!w_wake) begin
                        r_hcnt <= '0;
                        if (hold_cycles == '0) begin
                            r_state    <= GATED;
                            r_ch_gated <= 1'b1;
                        end else begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_wake) begin
                        r_state <= RUN;
                        r_hcnt  <= '0;
                    end else if (w_hold_done) begin
                        r_state    <= GATED;
                        r_ch_gated <= 1'b1;
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                GATED: begin
                    if (w_wake) begin
                        r_state    <= RUN;
                        r_hcnt     <= '0;
                        r_ch_gated <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= RUN;
                    r_hcnt     <= '0;
                    r_ch_gated <= 1'b0;
                end
            endcase
        end
    end

    // Count cycles the clock was actually held off; saturate, clear has priority
    always_ff @(posedge clk) begin
        if (cptra_rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if ((r_state == GATED) && !w_ch_en && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    logic r_en_lat;

    // Behavioural ICG: enable latched while clk is low so the gated clock never glitches
    always_latch begin
        if (!clk) begin
            r_en_lat <= w_ch_en;
        end
    end

    assign clk_cg = clk & r_en_lat;

    assign ch_en        = w_ch_en;
    assign ch_gated     = r_ch_gated;
    assign gated_cycles = r_cnt;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gating controller top: wire-change detection shared by
// all channels, one clk_gate_ch per channel, and output packing.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int WIRE_W = 64,
    parameter int HOLD_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    cptra_rst,
    input  logic                    clk_gate_en,
    input  logic                    rdc_clk_dis,
    input  logic                    cpu_halt_status,
    input  logic [NUM_CH-1:0]       ch_busy,
    input  logic [NUM_CH-1:0]       ch_gate_mask,
    input  logic [HOLD_W-1:0]       hold_cycles,
    input  logic [WIRE_W-1:0]       generic_input_wires,
    input  logic                    cnt_clr,
    output logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH-1:0]       clk_cg,
    output logic [NUM_CH-1:0]       ch_gated,
    output logic [NUM_CH*CNT_W-1:0] gated_cycles
);

    logic [WIRE_W-1:0] r_wires_f;
    logic              w_wire_chg;

    // Previous-cycle copy of the wires; reset to zero so non-zero wires after reset wake everything
    always_ff @(posedge clk) begin
        if (cptra_rst) begin
            r_wires_f <= {WIRE_W{RST_WIRE}};
        end else begin
            r_wires_f <= generic_input_wires;
        end
    end

    assign w_wire_chg = (generic_input_wires != r_wires_f);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_gate_ch #(
            .HOLD_W (HOLD_W),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk             (clk),
            .cptra_rst       (cptra_rst),
            .clk_gate_en     (clk_gate_en),
            .rdc_clk_dis     (rdc_clk_dis),
            .cpu_halt_status (cpu_halt_status),
            .wire_chg        (w_wire_chg),
            .ch_busy         (ch_busy[g]),
            .ch_gate_mask    (ch_gate_mask[g]),
            .hold_cycles     (hold_cycles),
            .cnt_clr         (cnt_clr),
            .ch_en           (ch_en[g]),
            .clk_cg          (clk_cg[g]),
            .ch_gated        (ch_gated[g]),
            .gated_cycles    (gated_cycles[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

Multi-channel clock-gating controller, the parametrised successor to the single-pair Caliptra clock gate. It produces NUM_CH independent ICG enables and gated clocks from one free-running clock. Each channel has programmable idle hysteresis, so a clock is gated only after a set number of idle cycles and is re-enabled combinationally on any wake event. It also provides per-channel status and saturating gated-cycle counters for power telemetry. It sits at the top of the Caliptra clock tree, beside the RDC clock-disable logic.

## Interface
- NUM_CH, 2: number of gated clock channels (≥1)
- WIRE_W, 64: width of generic_input_wires
- HOLD_W, 8: width of hold_cycles and of the per-channel hysteresis counter
- CNT_W, 32: width of each gated-cycle counter
- clk  in  1  free-running clock; the only clock
- cptra_rst  in  1  reset, synchronous, active-high
- clk_gate_en  in  1  global gating enable; 0 keeps every channel running
- rdc_clk_dis  in  1  force all channels off immediately; overrides everything
- cpu_halt_status  in  1  core halted; required for any gating
- ch_busy  in  NUM_CH  per-channel keep-alive (e.g. APB psel)
- ch_gate_mask  in  NUM_CH  1 = channel may gate
- hold_cycles  in  HOLD_W  idle cycles required before gating (shared)
- generic_input_wires  in  WIRE_W  any change is a wake event for all channels
- cnt_clr  in  1  synchronous clear of all gated-cycle counters
- ch_en  out  NUM_CH  ICG enable per channel
- clk_cg  out  NUM_CH  gated clocks, one `CALIPTRA_ICG` / `USER_ICG` per channel
- ch_gated  out  NUM_CH  registered: 1 while channel FSM is GATED
- gated_cycles  out  NUM_CH*CNT_W  per-channel counters, channel i at [i*CNT_W +: CNT_W]

## Operation
- wires_f: register of generic_input_wires, reset 0; wire_chg = (generic_input_wires != wires_f).
- wake[i] = wire_chg | !cpu_halt_status | ch_busy[i] | !clk_gate_en | !ch_gate_mask[i].
- Per-channel FSM, states RUN, HOLD, GATED; reset state RUN; hold counter hcnt resets to 0.
  - RUN: if !wake[i], go to HOLD with hcnt=0. If hold_cycles==0, go directly to GATED.
  - HOLD: if wake[i], go to RUN. Else if hcnt==hold_cycles-1, go to GATED. Else hcnt++.
  - GATED: if wake[i], go to RUN.
  - If rdc_clk_dis, next state is RUN and hcnt=0, regardless of current state.
- ch_en[i] = !rdc_clk_dis & ((state != GATED) | wake[i]). Combinational, so a wake takes effect with zero-cycle latency.
- ch_gated[i] = (state==GATED), registered, reset 0.
- gated_cycles[i] increments on each clk where state==GATED and ch_en[i]==0. It saturates at all-ones and never wraps. cnt_clr wins over increment. Reset value 0.
- hold_cycles is sampled every cycle. If it changes mid-HOLD, the new value applies from the next compare. If hcnt is already ≥ hold_cycles-1, the FSM gates on that edge.

## Timing
- Continuous idle from cycle 0 puts the FSM in GATED after hold_cycles+1 rising edges; ch_en drops in the following cycle.
- The first cycle after reset with non-zero wires reads as a change (wires_f=0), which wakes all channels; this is required behaviour.
- A wire change is a single-cycle wake. The FSM returns to RUN and hysteresis restarts from 0.
- When wake and the HOLD→GATED compare occur together, wake wins.
- During reset, ch_en = !rdc_clk_dis, ch_gated=0, and counters are 0.

## Structure
- clk_gate_pkg holds the state enum typedef (RUN/HOLD/GATED, 2 bits) and reset-value localparams.
- Sub-module clk_gate_ch holds one channel's FSM, hcnt, ch_en logic, gated counter and ICG macro. It is instantiated NUM_CH times in a generate loop.
- The top level holds only wires_f, wire_chg, and the output packing.

## Test plan
- NUM_CH=2, hold_cycles=4, halt=1, clk_gate_en=1, mask=2'b11, busy=0, wires static → ch_gated rises after 5 edges; ch_en=2'b00; gated_cycles count each cycle after that.
- From GATED, toggle generic_input_wires[17] for one cycle → ch_en=2'b11 in the same cycle, FSM RUN; re-gates 5 edges after the toggle clears.
- ch_busy=2'b10 held → channel 0 gates after 5 edges; channel 1 stays RUN with ch_en[1]=1 and its counter at 0.
- rdc_clk_dis pulsed for 2 cycles at hcnt=2 → ch_en=0 on both channels during the pulse; after release, gating needs a fresh 5 edges.
- CNT_W=4, channel gated for 20 cycles → counter holds 15. cnt_clr in the same cycle as an increment → 0, then 1 on the next cycle.
- cptra_rst asserted while GATED → ch_en=1 and ch_gated=0 during reset, counters 0; hold_cycles=0 then gates on the first idle edge.
